int_lane_alu_slave: RTL and testbench



---
 rtl/int_lane_alu_slave_if.sv | 21 ++
 rtl/int_lane_alu_slave.sv | 193 +++++++++++++++++++
 tb/tb_int_lane_alu_slave.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_lane_alu_slave_if.sv
// rtl/int_lane_alu_slave_if.sv - shared memory-mapped bus for the lane ALU slave
interface int_lane_alu_slave_if #(
  parameter int DATA_W = 256
);
  logic [15:0]       address;
  logic              nRead;
  logic              nWrite;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] DataOut;
  logic              Irq;

  modport master (
    output address, nRead, nWrite, DataIn,
    input  DataOut, Irq
  );

  modport slave (
    input  address, nRead, nWrite, DataIn,
    output DataOut, Irq
  );
endinterface

// File: rtl/int_lane_alu_slave.sv
// rtl/int_lane_alu_slave.sv - memory-mapped SIMD integer ALU with lane-serial multiply
module int_lane_alu_slave #(
  parameter int          DATA_W    = 256,
  parameter int          LANE_W    = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0100
) (
  input logic                 Clk,
  input logic                 Reset,
  int_lane_alu_slave_if.slave bus
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] src_a_q, src_b_q, result_q, stage_q, opa_q, opb_q;
  logic [4:0]        ctrl_q;
  logic [2:0]        op_q;
  logic              sgn_q, sat_q, done_q, err_q, irq_q;
  logic [LANES-1:0]  ovf_q;
  logic [LW-1:0]     lane_q;

  logic [15:0] off;
  logic        hit, wr_en, rd_en, start_req, busy;

  assign off       = bus.address - BASE_ADDR;
  assign hit       = off < 16'd5;
  assign wr_en     = hit && !bus.nWrite;
  assign rd_en     = hit && !bus.nRead;
  assign start_req = wr_en && (off == 16'd2) && bus.DataIn[8];
  assign busy      = (state_q != IDLE);

  // Single-lane ADD/SUB/logic/MIN/MAX; returns {overflow, result}
  function automatic logic [LANE_W:0] lane_op(
    input logic [2:0]        op,
    input logic              sgn,
    input logic              sat,
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b
  );
    logic [LANE_W:0]   ext;
    logic [LANE_W-1:0] r;
    logic              ov, lt;
    ext = (op == 3'd1) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
    r   = '0;
    ov  = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        r = ext[LANE_W-1:0];
        // Signed overflow: operand signs agree (ADD) or differ (SUB) and result sign flips
        if (sgn) ov = ((a[LANE_W-1] ^ b[LANE_W-1]) == (op == 3'd1)) && (r[LANE_W-1] != a[LANE_W-1]);
        else     ov = ext[LANE_W];
        if (ov && sat) begin
          if (sgn) r = a[LANE_W-1] ? SMIN : SMAX;
          else     r = (op == 3'd1) ? '0 : '1;
        end
      end
      3'd3:    r = a & b;
      3'd4:    r = a | b;
      3'd5:    r = a ^ b;
      3'd6:    r = lt ? a : b;
      3'd7:    r = lt ? b : a;
      default: r = '0;
    endcase
    return {ov, r};
  endfunction

  logic [DATA_W-1:0] alu_d;
  logic [LANES-1:0]  alu_ov_d;

  // All lanes of the single-cycle ops in parallel from the snapshotted operands
  always_comb begin
    alu_d    = '0;
    alu_ov_d = '0;
    for (int i = 0; i < LANES; i++) begin
      {alu_ov_d[i], alu_d[i*LANE_W +: LANE_W]} =
        lane_op(op_q, sgn_q, sat_q, opa_q[i*LANE_W +: LANE_W], opb_q[i*LANE_W +: LANE_W]);
    end
  end

  logic [LANE_W-1:0]   mul_a, mul_b, mul_r;
  logic [2*LANE_W-1:0] mul_xa, mul_xb, mul_p;
  logic                mul_ov;

  // One shared multiplier, fed by the lane selected by lane_q
  always_comb begin
    mul_a  = opa_q[lane_q*LANE_W +: LANE_W];
    mul_b  = opb_q[lane_q*LANE_W +: LANE_W];
    mul_xa = sgn_q ? {{LANE_W{mul_a[LANE_W-1]}}, mul_a} : {{LANE_W{1'b0}}, mul_a};
    mul_xb = sgn_q ? {{LANE_W{mul_b[LANE_W-1]}}, mul_b} : {{LANE_W{1'b0}}, mul_b};
    mul_p  = mul_xa * mul_xb;
    if (sgn_q) mul_ov = !((&mul_p[2*LANE_W-1:LANE_W-1]) || !(|mul_p[2*LANE_W-1:LANE_W-1]));
    else       mul_ov = |mul_p[2*LANE_W-1:LANE_W];
    mul_r = mul_p[LANE_W-1:0];
    if (mul_ov && sat_q) mul_r = sgn_q ? (mul_p[2*LANE_W-1] ? SMIN : SMAX) : '1;
  end

  // Register file writes plus the IDLE -> EXEC -> DONE operation sequencer
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      src_a_q  <= '0;
      src_b_q  <= '0;
      result_q <= '0;
      stage_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      ctrl_q   <= '0;
      op_q     <= '0;
      sgn_q    <= 1'b0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      ovf_q    <= '0;
      lane_q   <= '0;
    end else begin
      irq_q <= 1'b0;
      if (wr_en && off == 16'd0) src_a_q <= bus.DataIn;
      if (wr_en && off == 16'd1) src_b_q <= bus.DataIn;
      if (wr_en && off == 16'd2) ctrl_q  <= bus.DataIn[4:0];
      if (rd_en && off == 16'd4) done_q  <= 1'b0;
      if (start_req && busy)     err_q   <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_req) begin
            op_q    <= bus.DataIn[2:0];
            sgn_q   <= bus.DataIn[3];
            sat_q   <= bus.DataIn[4];
            opa_q   <= src_a_q;
            opb_q   <= src_b_q;
            ovf_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= '0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == 3'd2) begin
            result_q[lane_q*LANE_W +: LANE_W] <= mul_r;
            ovf_q[lane_q] <= mul_ov;
            lane_q        <= lane_q + 1'b1;
            if (lane_q == LW'(LANES-1)) begin
              state_q <= DONE;
              irq_q   <= 1'b1;
            end
          end else begin
            stage_q <= alu_d;
            ovf_q   <= alu_ov_d;
            state_q <= DONE;
            irq_q   <= 1'b1;
          end
        end
        DONE: begin
          if (op_q != 3'd2) result_q <= stage_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0] status_w, rdata;

  // Combinational read mux; zero unless a read hits the block
  always_comb begin
    status_w             = '0;
    status_w[0]          = busy;
    status_w[1]          = done_q;
    status_w[2]          = err_q;
    status_w[16 +: LANES] = ovf_q;
    rdata                = '0;
    if (rd_en) begin
      case (off)
        16'd0:   rdata = src_a_q;
        16'd1:   rdata = src_b_q;
        16'd2:   rdata = DATA_W'(ctrl_q);
        16'd3:   rdata = result_q;
        16'd4:   rdata = status_w;
        default: rdata = '0;
      endcase
    end
  end

  assign bus.DataOut = rdata;
  assign bus.Irq     = irq_q;
endmodule

// File: tb/tb_int_lane_alu_slave.sv
// tb/tb_int_lane_alu_slave.sv - directed and randomized bench for int_lane_alu_slave
module tb_int_lane_alu_slave;
  localparam int          DATA_W    = 256;
  localparam int          LANE_W    = 16;
  localparam int          LANES     = DATA_W / LANE_W;
  localparam logic [15:0] BASE_ADDR = 16'h0100;

  logic Clk;
  logic Reset;
  int   n_pass;
  int   n_total;

  logic [DATA_W-1:0] prev_res;
  logic              err_m;

  int_lane_alu_slave_if #(.DATA_W(DATA_W)) bus ();

  int_lane_alu_slave #(.DATA_W(DATA_W), .LANE_W(LANE_W), .BASE_ADDR(BASE_ADDR)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bus_write(input int off, input logic [DATA_W-1:0] d);
    bus.address = BASE_ADDR + 16'(off);
    bus.DataIn  = d;
    bus.nWrite  = 1'b0;
    @(posedge Clk);
    #1;
    bus.nWrite = 1'b1;
  endtask

  task automatic bus_read(input int off, output logic [DATA_W-1:0] v);
    bus.address = BASE_ADDR + 16'(off);
    bus.nRead   = 1'b0;
    #1;
    v = bus.DataOut;
    bus.nRead = 1'b1;
    #1;
  endtask

  // Reference lane: true mathematical value, then range check, clamp or wrap
  function automatic logic [16:0] model_lane(input logic [2:0] op, input logic sgn, input logic sat,
                                             input logic [15:0] a, input logic [15:0] b);
    longint va, vb, t, lo, hi;
    logic   ov;
    va = sgn ? longint'($signed(a)) : longint'(a);
    vb = sgn ? longint'($signed(b)) : longint'(b);
    lo = sgn ? -32768 : 0;
    hi = sgn ? 32767 : 65535;
    case (op)
      3'd0:    t = va + vb;
      3'd1:    t = va - vb;
      3'd2:    t = va * vb;
      3'd3:    t = longint'(a & b);
      3'd4:    t = longint'(a | b);
      3'd5:    t = longint'(a ^ b);
      3'd6:    t = (va < vb) ? va : vb;
      default: t = (va > vb) ? va : vb;
    endcase
    ov = (op <= 3'd2) && (t < lo || t > hi);
    if (ov && sat) t = (t < lo) ? lo : hi;
    return {ov, t[15:0]};
  endfunction

  task automatic model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [4:0] c,
                       output logic [DATA_W-1:0] r, output logic [LANES-1:0] ov);
    logic [16:0] x;
    for (int i = 0; i < LANES; i++) begin
      x = model_lane(c[2:0], c[3], c[4], a[i*16 +: 16], b[i*16 +: 16]);
      r[i*16 +: 16] = x[15:0];
      ov[i] = x[16];
    end
  endtask

  function automatic logic [DATA_W-1:0] stat(input logic busy, input logic done, input logic err,
                                             input logic [LANES-1:0] ov);
    logic [DATA_W-1:0] s;
    s = '0;
    s[0] = busy;
    s[1] = done;
    s[2] = err;
    s[16 +: LANES] = ov;
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] rand_vec();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i*16 +: 16] = 16'h7FFF;
        1:       v[i*16 +: 16] = 16'h8000;
        2:       v[i*16 +: 16] = 16'hFFFF;
        3:       v[i*16 +: 16] = 16'h0000;
        default: v[i*16 +: 16] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  // Full operation: load operands, start, check timing, Irq pulse, Result and Status
  task automatic run_op(input string tag, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [4:0] c, input bit inj);
    logic [DATA_W-1:0] er, v, part;
    logic [LANES-1:0]  eo;
    model(a, b, c, er, eo);
    bus_write(0, a);
    bus_write(1, b);
    bus_write(2, DATA_W'(9'h100) | DATA_W'(c));
    err_m = 1'b0;
    check({tag, " irq_at_start"}, DATA_W'(bus.Irq), '0);
    bus_read(4, v);
    check({tag, " status_at_start"}, DATA_W'(v[2:0]), DATA_W'(3'b001));
    if (c[2:0] == 3'd2) begin
      for (int k = 1; k <= LANES; k++) begin
        if (inj && k == 3) begin
          bus_write(2, DATA_W'(9'h100));
          err_m = 1'b1;
        end else if (inj && k == 5) begin
          bus_write(0, ~a);
        end else begin
          @(posedge Clk);
          #1;
        end
        if (k == LANES / 2) begin
          for (int i = 0; i < LANES; i++)
            part[i*16 +: 16] = (i < k) ? er[i*16 +: 16] : prev_res[i*16 +: 16];
          bus_read(3, v);
          check({tag, " mul_partial"}, v, part);
        end
      end
    end else begin
      @(posedge Clk);
      #1;
      bus_read(3, v);
      check({tag, " result_while_busy"}, v, prev_res);
    end
    check({tag, " irq_pulse"}, DATA_W'(bus.Irq), DATA_W'(1'b1));
    bus_read(4, v);
    check({tag, " status_in_done"}, DATA_W'(v[2:0]), DATA_W'({err_m, 2'b01}));
    @(posedge Clk);
    #1;
    check({tag, " irq_after"}, DATA_W'(bus.Irq), '0);
    bus_read(3, v);
    check({tag, " result"}, v, er);
    bus_read(4, v);
    check({tag, " status"}, v, stat(1'b0, 1'b1, err_m, eo));
    if (inj) begin
      bus_read(0, v);
      check({tag, " srca_written_busy"}, v, ~a);
    end
    prev_res = er;
  endtask

  initial begin
    logic [DATA_W-1:0] a, b, v;
    logic [4:0]        c;
    bit                irq_seen;
    n_pass      = 0;
    n_total     = 0;
    prev_res    = '0;
    err_m       = 1'b0;
    Reset       = 1'b1;
    bus.address = 16'h0000;
    bus.nRead   = 1'b1;
    bus.nWrite  = 1'b1;
    bus.DataIn  = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Reset state
    for (int r = 0; r < 5; r++) begin
      bus_read(r, v);
      check($sformatf("reset_reg%0d", r), v, '0);
    end
    check("reset_irq", DATA_W'(bus.Irq), '0);
    bus.address = BASE_ADDR;
    #1;
    check("dataout_no_read", bus.DataOut, '0);
    @(posedge Clk);
    #1;

    // Signed saturating ADD at the positive limit
    run_op("sadd_sat", {LANES{16'h7FFF}}, {LANES{16'h0001}}, 5'b11000, 1'b0);
    bus_read(3, v);
    check("sadd_sat_const", v, {LANES{16'h7FFF}});
    bus_read(4, v);
    check("sadd_sat_ovmask", DATA_W'(v[31:16]), DATA_W'(16'hFFFF));
    bus_read(2, v);
    check("ctrl_readback", v, DATA_W'(5'h18));

    // Reading Status clears done on the read edge
    bus.address = BASE_ADDR + 16'd4;
    bus.nRead   = 1'b0;
    #1;
    check("done_before_clear", DATA_W'(bus.DataOut[1]), DATA_W'(1'b1));
    @(posedge Clk);
    #1;
    check("done_after_clear", DATA_W'(bus.DataOut[1]), '0);
    bus.nRead = 1'b1;

    // Unsigned MUL with a busy-time start and SrcA write
    a = {LANES{16'd2}};
    b = {LANES{16'd3}};
    a[3*16 +: 16] = 16'd300;
    b[3*16 +: 16] = 16'd300;
    run_op("umul", a, b, 5'b00010, 1'b1);
    bus_read(3, v);
    check("umul_lane3", DATA_W'(v[3*16 +: 16]), DATA_W'(16'h5F90));
    check("umul_lane0", DATA_W'(v[15:0]), DATA_W'(16'h0006));
    bus_read(4, v);
    check("umul_ovmask_err", DATA_W'({v[31:16], v[2]}), DATA_W'({16'h0008, 1'b1}));

    // Unsigned ADD wrap; this start also clears err
    a = {LANES{16'd1}};
    b = {LANES{16'd1}};
    a[15:0] = 16'hFFFF;
    b[15:0] = 16'h0002;
    run_op("uadd_wrap", a, b, 5'b00000, 1'b0);
    bus_read(3, v);
    check("uadd_wrap_lanes", DATA_W'({v[31:16], v[15:0]}), DATA_W'({16'h0002, 16'h0001}));

    // Simultaneous read/write returns the pre-edge value
    bus.address = BASE_ADDR;
    bus.DataIn  = {LANES{16'hA5C3}};
    bus.nWrite  = 1'b0;
    bus.nRead   = 1'b0;
    #1;
    check("rw_pre_edge", bus.DataOut, a);
    @(posedge Clk);
    #1;
    check("rw_post_edge", bus.DataOut, {LANES{16'hA5C3}});
    bus.nWrite = 1'b1;
    bus.nRead  = 1'b1;

    // Ignored writes: outside the window and to read-only offsets
    bus_write(5, '1);
    bus_write(-1, '1);
    bus_write(3, '1);
    bus_write(4, '1);
    bus_read(0, v);
    check("ignored_srca", v, {LANES{16'hA5C3}});
    bus_read(3, v);
    check("ignored_result", v, prev_res);
    bus_read(5, v);
    check("read_out_of_range", v, '0);

    // Randomized operations against the reference model
    for (int n = 0; n < 16; n++) begin
      c = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d_op%0d", n, c[2:0]), rand_vec(), rand_vec(), c, 1'b0);
    end

    // Asynchronous reset in the middle of a MUL
    bus_write(0, rand_vec());
    bus_write(1, rand_vec());
    bus_write(2, DATA_W'(9'h102));
    repeat (4) @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    bus_read(3, v);
    check("abort_result", v, '0);
    bus_read(4, v);
    check("abort_status", v, '0);
    check("abort_irq", DATA_W'(bus.Irq), '0);
    @(posedge Clk);
    #3;
    Reset    = 1'b0;
    irq_seen = 1'b0;
    for (int k = 0; k < LANES + 3; k++) begin
      @(posedge Clk);
      #1;
      irq_seen = irq_seen | bus.Irq;
    end
    check("abort_no_irq", DATA_W'(irq_seen), '0);
    prev_res = '0;
    err_m    = 1'b0;
    run_op("ssub_after_abort", {LANES{16'd5}}, {LANES{16'd7}}, 5'b01001, 1'b0);
    bus_read(3, v);
    check("ssub_const", v, {LANES{16'hFFFE}});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
